data_memory_lsu: RTL and testbench
==================================

// Module: data_memory_lsu
// PURPOSE
//  Parametrised RISC-V data memory with a load/store unit front end.
//  - Supports byte, half and word accesses, with sign/zero extension on loads.
//  - Detects misaligned and out-of-range accesses.
//  - Valid/ready request port; read pipeline latency is configurable.
//  - Optional hardware clear of the array after reset.
//  - Sits between the EX/MEM stage and the writeback mux of the core.
// PARAMETERS
//  DEPTH           64  number of 32-bit words; power of 2, >= 4
//  READ_LATENCY    1   cycles from request accept to response; range 1..4
//  CLEAR_ON_RESET  1   1: zero every word after reset (DEPTH cycles); 0: no clear
// PORTS
//  CLK        in   1   clock, rising edge
//  RST        in   1   reset; synchronous, active-high
//  REQ_VALID  in   1   request present
//  REQ_READY  out  1   block can accept; a request is accepted when REQ_VALID & REQ_READY
//  WE         in   1   1 = store, 0 = load
//  A          in   32  byte address
//  WD         in   32  store data; payload taken from the low bytes
//  FUNCT3     in   3   access size: 000 LB/SB, 001 LH/SH, 010 LW/SW, 100 LBU, 101 LHU
//  RSP_VALID  out  1   response valid, one cycle per accepted request
//  RD         out  32  load result, already extended; 0 for stores and on error
//  ERR        out  1   access fault, qualified by RSP_VALID
// BEHAVIOUR
//  Reset and outputs
//   - On RST: REQ_READY=0, RSP_VALID=0, RD=0, ERR=0.
//   - All pipeline stages are invalidated. In-flight requests are dropped and get no response.
//  FSM: CLEAR -> IDLE
//   - CLEAR (entered on RST when CLEAR_ON_RESET=1)
//     - One word is zeroed per cycle, at index 0..DEPTH-1.
//     - REQ_READY=0.
//     - Goes to IDLE after word DEPTH-1 is written.
//     - RST asserted during CLEAR restarts the clear at index 0.
//   - With CLEAR_ON_RESET=0, the FSM goes straight to IDLE in the cycle after RST deasserts. Memory contents are retained.
//   - IDLE: REQ_READY=1 every cycle. One request is accepted per cycle and no back-pressure is applied.
//  Addressing
//   - Word index = A[log2(DEPTH)+1:2]; byte lane = A[1:0].
//   - Out of range if any bit of A[31:log2(DEPTH)+2] is set.
//   - Misaligned if: half access with A[0]=1, word access with A[1:0]!=0, or FUNCT3 is 011, 110 or 111 (illegal encoding).
//   - Faulting request: no array write; response has ERR=1 and RD=0.
//  Stores
//   - Commit on the accept edge.
//   - Byte enables come from size and lane: SB writes WD[7:0] to lane A[1:0]; SH writes WD[15:0] to lanes A[1]*2 and A[1]*2+1; SW writes all 4 lanes.
//   - Unselected bytes are unchanged.
//  Loads
//   - The array is read on the accept edge, after all earlier stores have committed.
//   - A load accepted the cycle after a store to the same word returns the new data.
//   - The selected lane is shifted to bit 0. LB/LH sign-extend; LBU/LHU zero-extend.
//  Latency
//   - RSP_VALID rises exactly READ_LATENCY cycles after the accept edge, for loads and stores alike (stores are acknowledged).
//   - Responses are in order; back-to-back requests give back-to-back responses.
//   - With no response due: RSP_VALID=0, RD=0, ERR=0.
// TESTING
//  1. RST for 1 cycle, CLEAR_ON_RESET=1, DEPTH=64 -> REQ_READY low for 64 cycles, then high. A LW at every address returns 0.
//  2. SW 0x8000_00F1 @0x10, then LB/LBU @0x10 -> RD=0xFFFF_FFF1 / 0x0000_00F1. LH @0x12 -> 0xFFFF_8000. LHU @0x12 -> 0x0000_8000.
//  3. SW 0x1122_3344 @0x20, SB 0xAA @0x21, SH 0xBEEF @0x22, LW @0x20 -> 0xBEEF_AA44.
//  4. LW @0x21, SH @0x03, LW @0x100 (DEPTH=64) -> ERR=1, RD=0. A following LW of the touched words shows them unchanged.
//  5. READ_LATENCY=3: 4 back-to-back requests -> 4 consecutive responses, starting 3 cycles after the first accept, in order.
//  6. RST while 2 loads are in flight and during CLEAR at index 20 -> no responses. Clear restarts and takes the full 64 cycles.

Source files
------------

// File: rtl/data_memory_lsu_if.sv
// Request/response bus between the EX/MEM stage and the data memory LSU.
// The master issues load/store requests; the slave returns one in-order response per request.
interface data_memory_lsu_if;
    logic        req_valid;
    logic        req_ready;
    logic        we;
    logic [31:0] a;
    logic [31:0] wd;
    logic [2:0]  funct3;
    logic        rsp_valid;
    logic [31:0] rd;
    logic        err;

    modport master (
        output req_valid, we, a, wd, funct3,
        input  req_ready, rsp_valid, rd, err
    );

    modport slave (
        input  req_valid, we, a, wd, funct3,
        output req_ready, rsp_valid, rd, err
    );
endinterface

// File: rtl/data_memory_lsu.sv
// RISC-V data memory with a load/store front end.
// Byte/half/word accesses with sign or zero extension on loads, alignment and range faults,
// a fixed-latency in-order response pipeline and an optional post-reset clear of the array.
module data_memory_lsu #(
    parameter int unsigned DEPTH          = 64,
    parameter int unsigned READ_LATENCY   = 1,
    parameter bit          CLEAR_ON_RESET = 1'b1
) (
    input logic               clk,
    input logic               rst,
    data_memory_lsu_if.slave  bus
);

    localparam int unsigned IDX_W = $clog2(DEPTH);

    typedef enum logic [0:0] {
        StClear,
        StIdle
    } state_e;

    state_e           state_q;
    logic [IDX_W-1:0] clr_idx_q;
    logic             ready_q;

    logic [31:0]      mem [DEPTH];

    logic             accept;
    logic             clear_we;
    logic             store_we;

    logic [IDX_W-1:0] idx;
    logic [1:0]       lane;
    logic             out_of_range;
    logic             misaligned;
    logic             fault;
    logic [3:0]       byte_en;
    logic [31:0]      wdata;
    logic [31:0]      word;
    logic [7:0]       byte_sel;
    logic [15:0]      half_sel;
    logic [31:0]      load_val;
    logic [31:0]      rsp_rd_next;

    logic [READ_LATENCY-1:0] pipe_valid_q;
    logic [READ_LATENCY-1:0] pipe_err_q;
    logic [31:0]             pipe_rd_q [READ_LATENCY];

    // A request held across the reset edge is dropped, never accepted.
    assign accept   = bus.req_valid & ready_q & ~rst;
    assign clear_we = (state_q == StClear) & ~rst;
    assign store_we = accept & bus.we & ~fault;

    assign bus.req_ready = ready_q;
    assign bus.rsp_valid = pipe_valid_q[READ_LATENCY-1];
    assign bus.rd        = pipe_rd_q[READ_LATENCY-1];
    assign bus.err       = pipe_err_q[READ_LATENCY-1];

    // Clear/idle FSM; ready is registered so it rises the cycle after the clear finishes.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= CLEAR_ON_RESET ? StClear : StIdle;
            clr_idx_q <= '0;
            ready_q   <= 1'b0;
        end else begin
            unique case (state_q)
                StClear: begin
                    ready_q   <= 1'b0;
                    clr_idx_q <= clr_idx_q + 1'b1;
                    if (clr_idx_q == IDX_W'(DEPTH - 1)) begin
                        state_q <= StIdle;
                        ready_q <= 1'b1;
                    end
                end
                StIdle: begin
                    ready_q <= 1'b1;
                end
                default: begin
                    state_q <= StIdle;
                    ready_q <= 1'b0;
                end
            endcase
        end
    end

    // Address decode, fault detection, byte enables and load extension.
    always_comb begin
        idx          = bus.a[IDX_W+1:2];
        lane         = bus.a[1:0];
        out_of_range = |bus.a[31:IDX_W+2];
        misaligned   = 1'b0;
        byte_en      = 4'b0000;
        wdata        = bus.wd;

        unique case (bus.funct3)
            3'b000, 3'b100: begin
                byte_en = 4'b0001 << lane;
                wdata   = {4{bus.wd[7:0]}};
            end
            3'b001, 3'b101: begin
                misaligned = bus.a[0];
                byte_en    = bus.a[1] ? 4'b1100 : 4'b0011;
                wdata      = {2{bus.wd[15:0]}};
            end
            3'b010: begin
                misaligned = (lane != 2'b00);
                byte_en    = 4'b1111;
            end
            default: begin
                // 011, 110, 111 are not legal access sizes.
                misaligned = 1'b1;
            end
        endcase

        fault = out_of_range | misaligned;

        // Earlier stores committed on earlier edges, so the array already holds their data.
        word     = mem[idx];
        byte_sel = word[{lane, 3'b000} +: 8];
        half_sel = bus.a[1] ? word[31:16] : word[15:0];

        unique case (bus.funct3)
            3'b000:  load_val = {{24{byte_sel[7]}}, byte_sel};
            3'b001:  load_val = {{16{half_sel[15]}}, half_sel};
            3'b010:  load_val = word;
            3'b100:  load_val = {24'h000000, byte_sel};
            3'b101:  load_val = {16'h0000, half_sel};
            default: load_val = 32'h0000_0000;
        endcase

        rsp_rd_next = (bus.we | fault) ? 32'h0000_0000 : load_val;
    end

    // Array write port: clear sweep has priority (no requests are accepted while clearing).
    always_ff @(posedge clk) begin
        if (clear_we) begin
            mem[clr_idx_q] <= 32'h0000_0000;
        end else if (store_we) begin
            for (int b = 0; b < 4; b++) begin
                if (byte_en[b]) begin
                    mem[idx][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
        end
    end

    // Response pipeline; empty slots carry zero data so idle outputs read as 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            pipe_valid_q <= '0;
            pipe_err_q   <= '0;
            for (int i = 0; i < int'(READ_LATENCY); i++) begin
                pipe_rd_q[i] <= 32'h0000_0000;
            end
        end else begin
            pipe_valid_q[0] <= accept;
            pipe_err_q[0]   <= accept & fault;
            pipe_rd_q[0]    <= accept ? rsp_rd_next : 32'h0000_0000;
            for (int i = 1; i < int'(READ_LATENCY); i++) begin
                pipe_valid_q[i] <= pipe_valid_q[i-1];
                pipe_err_q[i]   <= pipe_err_q[i-1];
                pipe_rd_q[i]    <= pipe_rd_q[i-1];
            end
        end
    end

endmodule

// File: tb/tb_data_memory_lsu.sv
// Self-checking bench for data_memory_lsu: byte-addressed reference model plus literal pins.
module tb_data_memory_lsu;

    localparam int unsigned DEPTH = 64;
    localparam int unsigned LAT   = 3;

    localparam logic [2:0] F_B  = 3'b000;
    localparam logic [2:0] F_H  = 3'b001;
    localparam logic [2:0] F_W  = 3'b010;
    localparam logic [2:0] F_BU = 3'b100;
    localparam logic [2:0] F_HU = 3'b101;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    data_memory_lsu_if bus ();

    data_memory_lsu #(
        .DEPTH          (DEPTH),
        .READ_LATENCY   (LAT),
        .CLEAR_ON_RESET (1'b1)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        int          due;
        logic [31:0] rd;
        logic        err;
        bit          lit_en;
        logic [31:0] lit_rd;
        logic        lit_err;
    } rsp_t;

    rsp_t        exp_q [$];
    rsp_t        cmp_e;
    logic [7:0]  mem_m [DEPTH*4];
    int          cyc        = 0;
    int          clear_left = DEPTH;
    int          errors     = 0;
    int          checks     = 0;
    bit          chk_en     = 1'b0;

    // Cycle counter and expected clear progress (ready once the clear count reaches zero).
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst) clear_left <= DEPTH;
        else if (clear_left != 0) clear_left <= clear_left - 1;
    end

    // Reference model for one accepted request, working on a flat byte array.
    task automatic model_req(input logic we, input logic [31:0] a, input logic [31:0] wd,
                             input logic [2:0] f3, input bit lit_en, input logic [31:0] lit_rd,
                             input logic lit_err);
        rsp_t        e;
        int          size;
        bit          bad;
        logic [31:0] v;
        e.due     = cyc + LAT - 1;
        e.rd      = 32'h0;
        e.err     = 1'b0;
        e.lit_en  = lit_en;
        e.lit_rd  = lit_rd;
        e.lit_err = lit_err;
        case (f3)
            F_B, F_BU: size = 1;
            F_H, F_HU: size = 2;
            F_W:       size = 4;
            default:   size = 0;
        endcase
        bad = (size == 0);
        if (!bad) bad = ((a % size) != 0) || (a >= DEPTH * 4);
        if (bad) begin
            e.err = 1'b1;
        end else if (we) begin
            for (int k = 0; k < size; k++) mem_m[a + k] = wd[8*k +: 8];
        end else begin
            v = 32'h0;
            for (int k = 0; k < size; k++) v[8*k +: 8] = mem_m[a + k];
            if ((f3 == F_B || f3 == F_H) && v[8*size-1]) v = v | (32'hFFFF_FFFF << (8 * size));
            e.rd = v;
        end
        exp_q.push_back(e);
    endtask

    // One cycle of stimulus; the model sees the request only if the block was ready.
    task automatic req(input logic v, input logic we, input logic [31:0] a, input logic [31:0] wd,
                       input logic [2:0] f3, input bit lit_en, input logic [31:0] lit_rd,
                       input logic lit_err);
        bit pre_ready;
        pre_ready     = (clear_left == 0);
        bus.req_valid = v;
        bus.we        = we;
        bus.a         = a;
        bus.wd        = wd;
        bus.funct3    = f3;
        @(posedge clk);
        #1;
        if (v && pre_ready && !rst) model_req(we, a, wd, f3, lit_en, lit_rd, lit_err);
        bus.req_valid = 1'b0;
    endtask

    task automatic idle();
        req(1'b0, 1'b0, 32'h0, 32'h0, F_W, 1'b0, 32'h0, 1'b0);
    endtask

    task automatic ld(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] lit);
        req(1'b1, 1'b0, a, 32'h0, f3, 1'b1, lit, 1'b0);
    endtask

    task automatic st(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
        req(1'b1, 1'b1, a, wd, f3, 1'b1, 32'h0, 1'b0);
    endtask

    task automatic bad_req(input logic we, input logic [2:0] f3, input logic [31:0] a);
        req(1'b1, we, a, 32'hDEAD_BEEF, f3, 1'b1, 32'h0, 1'b1);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        exp_q.delete();
        for (int i = 0; i < int'(DEPTH * 4); i++) mem_m[i] = 8'h00;
        idle();
        rst = 1'b0;
    endtask

    task automatic wait_ready();
        int n;
        n = 0;
        while (!bus.req_ready && n < 200) begin
            idle();
            n++;
        end
        checks++;
        if (n != int'(DEPTH)) begin
            errors++;
            $display("FAIL clear_cycles: got %0d want %0d", n, DEPTH);
        end
    endtask

    task automatic drain();
        repeat (LAT + 1) idle();
    endtask

    // Per-cycle compare of ready and response against the model queue.
    always @(negedge clk) begin
        if (chk_en) begin
            checks++;
            if (bus.req_ready !== (clear_left == 0)) begin
                errors++;
                $display("FAIL ready cyc=%0d: got %b want %b", cyc, bus.req_ready,
                         clear_left == 0);
            end
            if (exp_q.size() != 0 && exp_q[0].due == cyc) begin
                cmp_e = exp_q.pop_front();
                checks++;
                if (bus.rsp_valid !== 1'b1 || bus.rd !== cmp_e.rd || bus.err !== cmp_e.err) begin
                    errors++;
                    $display("FAIL rsp cyc=%0d: got v=%b rd=%h err=%b want v=1 rd=%h err=%b",
                             cyc, bus.rsp_valid, bus.rd, bus.err, cmp_e.rd, cmp_e.err);
                end
                if (cmp_e.lit_en) begin
                    checks++;
                    if (bus.rd !== cmp_e.lit_rd || bus.err !== cmp_e.lit_err) begin
                        errors++;
                        $display("FAIL literal cyc=%0d: got rd=%h err=%b want rd=%h err=%b",
                                 cyc, bus.rd, bus.err, cmp_e.lit_rd, cmp_e.lit_err);
                    end
                end
            end else begin
                checks++;
                if (bus.rsp_valid !== 1'b0 || bus.rd !== 32'h0 || bus.err !== 1'b0) begin
                    errors++;
                    $display("FAIL idle_rsp cyc=%0d: got v=%b rd=%h err=%b want v=0 rd=0 err=0",
                             cyc, bus.rsp_valid, bus.rd, bus.err);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.req_valid = 1'b0;
        bus.we        = 1'b0;
        bus.a         = 32'h0;
        bus.wd        = 32'h0;
        bus.funct3    = F_W;

        // Reset, clear sweep, then every word reads zero.
        do_reset();
        chk_en = 1'b1;
        wait_ready();
        for (int i = 0; i < int'(DEPTH); i++) ld(F_W, 32'(i * 4), 32'h0);

        // Sign and zero extension.
        st(F_W, 32'h10, 32'h8000_00F1);
        ld(F_B,  32'h10, 32'hFFFF_FFF1);
        ld(F_BU, 32'h10, 32'h0000_00F1);
        ld(F_H,  32'h12, 32'hFFFF_8000);
        ld(F_HU, 32'h12, 32'h0000_8000);

        // Partial stores merge into one word.
        st(F_W, 32'h20, 32'h1122_3344);
        st(F_B, 32'h21, 32'h0000_00AA);
        st(F_H, 32'h22, 32'h0000_BEEF);
        ld(F_W, 32'h20, 32'hBEEF_AA44);

        // Faults: no write, ERR=1, RD=0.
        bad_req(1'b0, F_W, 32'h21);
        bad_req(1'b1, F_H, 32'h03);
        bad_req(1'b0, F_W, 32'h100);
        bad_req(1'b1, F_W, 32'h100);
        bad_req(1'b0, 3'b011, 32'h20);
        bad_req(1'b1, 3'b111, 32'h20);
        ld(F_W, 32'h20, 32'hBEEF_AA44);
        ld(F_W, 32'h00, 32'h0000_0000);
        ld(F_HU, 32'h02, 32'h0000_0000);

        // Back-to-back traffic, including a load right after a store to the same word.
        st(F_W, 32'h40, 32'hCAFE_F00D);
        ld(F_W, 32'h40, 32'hCAFE_F00D);
        ld(F_HU, 32'h42, 32'h0000_CAFE);
        ld(F_B, 32'h43, 32'hFFFF_FFCA);
        st(F_B, 32'hFC, 32'h0000_0080);
        ld(F_B, 32'hFC, 32'hFFFF_FF80);
        drain();

        // Reset with loads in flight, then again mid-clear; the clear restarts from index 0.
        ld(F_W, 32'h40, 32'h0);
        ld(F_W, 32'h44, 32'h0);
        do_reset();
        repeat (20) idle();
        do_reset();
        wait_ready();
        ld(F_W, 32'h40, 32'h0000_0000);
        ld(F_W, 32'h20, 32'h0000_0000);
        drain();

        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL pending: got %0d outstanding want 0", exp_q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
